// File: rtl/frame_sequencer.sv
// Pixel stream sequencer: tags each valid pixel with its frame position and
// line/frame strobes, and issues a post-frame flush strobe to the filter datapath.
module frame_sequencer #(
  parameter int unsigned WIDTH        = 800,
  parameter int unsigned HEIGHT       = 600,
  parameter int unsigned WIN          = 4,
  parameter int unsigned FLUSH_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [7:0]  din,
  input  logic        resync,
  output logic [7:0]  dout,
  output logic        dvalid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        sof,
  output logic        eof,
  output logic        sol,
  output logic        eol,
  output logic        border,
  output logic        flush,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  localparam logic [9:0]  LAST_COL   = 10'(WIDTH - 1);
  localparam logic [9:0]  LAST_ROW   = 10'(HEIGHT - 1);
  localparam logic [9:0]  BORDER_LIM = 10'(WIN - 1);
  localparam logic [15:0] FLUSH_INIT = 16'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [15:0] flush_left;
  logic        at_eol;
  logic        at_eof;

  always_comb begin
    at_eol = (col == LAST_COL);
    at_eof = at_eol && (row == LAST_ROW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      flush_left <= '0;
      dout       <= '0;
      dvalid     <= 1'b0;
      x          <= '0;
      y          <= '0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      sol        <= 1'b0;
      eol        <= 1'b0;
      border     <= 1'b0;
      flush      <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      dvalid <= 1'b0;
      sof    <= 1'b0;
      eof    <= 1'b0;
      sol    <= 1'b0;
      eol    <= 1'b0;
      border <= 1'b0;
      if (resync) begin
        state      <= IDLE;
        col        <= '0;
        row        <= '0;
        flush_left <= '0;
        flush      <= 1'b0;
        busy       <= 1'b0;
      end else if (valid) begin
        // Counters are already zero in IDLE/FLUSH, so the same path starts a frame
        // from either state and also aborts a running flush.
        dout   <= din;
        dvalid <= 1'b1;
        x      <= col;
        y      <= row;
        sof    <= (col == '0) && (row == '0);
        sol    <= (col == '0);
        eol    <= at_eol;
        eof    <= at_eof;
        border <= (col < BORDER_LIM) || (row < BORDER_LIM);
        busy   <= 1'b1;
        if (at_eof) begin
          col        <= '0;
          row        <= '0;
          frame_cnt  <= frame_cnt + 16'd1;
          state      <= FLUSH;
          flush      <= 1'b1;
          flush_left <= FLUSH_INIT;
        end else begin
          state <= ACTIVE;
          flush <= 1'b0;
          if (at_eol) begin
            col <= '0;
            row <= row + 10'd1;
          end else begin
            col <= col + 10'd1;
          end
        end
      end else if (state == FLUSH) begin
        if (flush_left == '0) begin
          flush <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          flush_left <= flush_left - 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
- REQ-001: Parameter WIDTH, default 800, active pixels per line.
- REQ-002: Parameter HEIGHT, default 600, active lines per frame.
- REQ-003: Parameter WIN, default 4, filter window size; the first WIN-1 columns and rows are border.
- REQ-004: Parameter FLUSH_CYCLES, default 8, flush pulse length after end of frame.
- REQ-005: Port clock, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
- REQ-006: Port reset, input, 1 bit, synchronous active-high reset.
- REQ-007: Port valid, input, 1 bit, upstream pixel valid.
- REQ-008: Port din, input, 8 bits, upstream pixel.
- REQ-009: Port resync, input, 1 bit, single-cycle request to drop the current frame and relock.
- REQ-010: Port dout, output, 8 bits, registered pixel to the filter datapath.
- REQ-011: Port dvalid, output, 1 bit, registered pixel valid to the datapath.
- REQ-012: Port x, output, 10 bits, column of the pixel on dout.
- REQ-013: Port y, output, 10 bits, row of the pixel on dout.
- REQ-014: Ports sof, eof, sol and eol, outputs, 1 bit each, first/last pixel of the frame/line, qualified by dvalid.
- REQ-015: Port border, output, 1 bit, high when x < WIN-1 or y < WIN-1, qualified by dvalid.
- REQ-016: Port flush, output, 1 bit, datapath pipeline flush strobe.
- REQ-017: Port busy, output, 1 bit, high when the state is not IDLE.
- REQ-018: Port frame_cnt, output, 16 bits, count of completed frames.

Function
- REQ-019: States SHALL be IDLE, ACTIVE and FLUSH.
- REQ-020: All outputs SHALL be registered; dout, dvalid, x, y, sof, eof, sol, eol and border SHALL appear exactly 1 cycle after the input pixel.
- REQ-021: In IDLE, the first valid pixel SHALL be taken as (0,0) with sof=1 and sol=1, and the state SHALL go to ACTIVE.
- REQ-022: Each valid pixel SHALL advance the internal column; cycles with valid=0 SHALL hold all counters, so blanking of any length is allowed.
- REQ-023: A valid pixel at column WIDTH-1 SHALL assert eol, wrap the column to 0 and increment the row; the next valid pixel SHALL assert sol.
- REQ-024: A valid pixel at (WIDTH-1, HEIGHT-1) SHALL assert eof and eol.
  - The same edge SHALL increment frame_cnt (wrapping at 65535->0), zero the counters and go to FLUSH.
- REQ-025: In FLUSH, flush SHALL be high for FLUSH_CYCLES consecutive cycles, starting the cycle after eof, then the state SHALL go to IDLE.
- REQ-026: A valid pixel in FLUSH SHALL abort the flush the same edge: flush low next cycle, the pixel is (0,0) of the next frame with sof=1, and the state goes to ACTIVE.
- REQ-027: resync=1 in any state SHALL force IDLE and zero the counters on the next edge.
  - dvalid, flush and all strobes SHALL be low that cycle.
  - Any pixel presented with resync SHALL be dropped.
  - frame_cnt SHALL be unchanged.
- REQ-028: When dvalid=0, dout, x and y SHALL hold their last values and sof, eof, sol, eol and border SHALL be 0.
- REQ-029: The counters SHALL never exceed WIDTH-1 and HEIGHT-1; WIDTH and HEIGHT SHALL be at most 1024.

Reset
- REQ-030: With reset=1 the next edge SHALL set the state to IDLE and zero the counters.
  - All outputs SHALL be 0, including frame_cnt.
- REQ-031: reset SHALL take priority over resync and valid; reset mid-frame SHALL discard the partial frame.
  - The first valid pixel after reset deasserts SHALL be (0,0).

Verification (WIDTH=4, HEIGHT=3, WIN=2, FLUSH_CYCLES=3 unless noted)
- REQ-032: Reset, then 12 consecutive valid pixels, din=0x00..0x0B.
  - Required: dvalid 1 cycle late; dout=0x00..0x0B; x=0,1,2,3 repeating; y=0,0,0,0,1,...,2.
  - Required: sof on the first pixel; eol on pixels 3, 7 and 11; eof on pixel 11; frame_cnt=1; flush high 3 cycles, then busy=0.
- REQ-033: Same frame with 2 idle cycles after every pixel.
  - Required: identical x/y/strobe sequence; dvalid low during gaps with strobes 0.
  - Required: border=1 exactly on x=0 or y=0 pixels, i.e. 6 of the 12 pixels.
- REQ-034: A valid pixel 1 cycle after the eof pixel.
  - Required: flush high 1 cycle only, that pixel has sof=1 with x=0, y=0, and busy stays 1.
- REQ-035: resync at pixel 6 of the frame, then 12 valid pixels.
  - Required: pixel 6 dropped, dvalid=0 that cycle, frame_cnt unchanged.
  - Required: the next pixel is (0,0) with sof, and the frame completes with frame_cnt incremented by 1.
- REQ-036: reset asserted at pixel 5, held 1 cycle with valid=1.
  - Required: all outputs 0 the next cycle, including frame_cnt.
  - Required: the first subsequent valid pixel is (0,0) with sof.
- REQ-037: Defaults (800x600) driven with 800 valid / 100 idle per line, 100 idle lines, 2 frames.
  - Required: eof exactly twice, at x=799, y=599; frame_cnt=2; 8 flush cycles after each eof.
